// File: rtl/arm_code_writer.sv
`default_nettype none
// ============================================================================
// Module   : arm_code_writer
// Purpose  : Buffers translated ARM instruction words in a small FIFO and
//            drains them into code memory through a req/ack word-write
//            port with an auto-incrementing address. Back-pressures the
//            translator through in_ready. At the end of a method, done
//            pulses for one cycle once the flush drain has completed.
// Optional : CODE_LIMIT_EN - adds limit_addr/overflow; writes stop at
//            limit_addr and the remaining FIFO contents are dropped.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            in_valid/in_inst/in_ready - translator word stream
//            base_load/base_addr - start address for the method (IDLE only)
//            flush           - end of method, drain then pulse done
//            mem_req/mem_addr/mem_wdata/mem_ack - code memory write port
//            busy, done, count - status; count = words acked since base_load
// Revision : 1.0 - initial release
// ============================================================================
module arm_code_writer #(
  parameter int DEPTH = 8,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [31:0]   in_inst,
  output logic          in_ready,
  input  logic          base_load,
  input  logic [AW-1:0] base_addr,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] count
`ifdef CODE_LIMIT_EN
  ,
  input  logic [AW-1:0] limit_addr,
  output logic          overflow
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [31:0]   fifo_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]   wr_ptr, rd_ptr;
  logic [AW-1:0] wr_addr, word_count;
  logic          empty, full, one_left;
  logic          push, pop, drain_done;
  logic          stall_req, stop_in, discard;

`ifdef CODE_LIMIT_EN
  logic limit_hit;
  assign limit_hit = !empty && (wr_addr == limit_addr);
  assign stall_req = limit_hit || overflow;
  assign stop_in   = overflow;
  assign discard   = overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (state == IDLE && base_load) begin
      overflow <= 1'b0;
    end else if (limit_hit) begin
      overflow <= 1'b1;
    end
  end
`else
  assign stall_req = 1'b0;
  assign stop_in   = 1'b0;
  assign discard   = 1'b0;
`endif

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign one_left = ((wr_ptr - rd_ptr) == (PW+1)'(1));

  // No bypass: a full FIFO refuses input even when a pop happens this cycle.
  assign in_ready  = !full && (state != FLUSH) && (state != DONE) && !stop_in;
  assign push      = in_valid && in_ready;
  assign mem_req   = !empty && (state != IDLE) && !stall_req;
  assign pop       = mem_req && mem_ack;
  assign mem_wdata = fifo_mem[rd_ptr[PW-1:0]];
  assign mem_addr  = wr_addr;
  assign count     = word_count;
  assign busy      = (state != IDLE) || !empty;
  assign done      = (state == DONE);

  // Looks one pop ahead so done follows the last ack by exactly one cycle;
  // a discarding FIFO is empty by the next cycle as well.
  assign drain_done = empty || (one_left && pop) || discard;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (push) begin
          state_next = flush ? FLUSH : RUN;
        end else if (flush) begin
          state_next = empty ? DONE : FLUSH;
        end
      end
      RUN: begin
        if (flush) state_next = FLUSH;
      end
      FLUSH: begin
        if (drain_done) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wr_addr    <= '0;
      word_count <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (discard) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + (PW+1)'(1);
      end
      if (state == IDLE && base_load) begin
        wr_addr    <= base_addr;
        word_count <= '0;
      end else if (pop) begin
        wr_addr    <= wr_addr + AW'(1);
        word_count <= word_count + AW'(1);
      end
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= in_inst;
  end

endmodule
`default_nettype wire
